mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the cache subsystem's single external memory port between NUM_REQ miss/write-back requesters, e.g. I-cache refill and D-cache refill/write-back.
- Each grant is one fixed-length burst of BURST_LEN beats: an address phase, then read or write data beats.
- Sits between the cache controllers and the memory interface.
- Arbitration is round-robin. The owner keeps the port for the whole burst.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data beat width
BURST_LEN, 4, beats per burst (power of 2, >=2)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
req_valid  in  NUM_REQ  request pending per requester; held until its req_gnt
req_we  in  NUM_REQ  1=write burst, 0=read burst
req_addr  in  NUM_REQ*ADDR_W  burst base address, requester i at [i*ADDR_W +: ADDR_W]
req_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
wdata  in  NUM_REQ*DATA_W  write beat per requester, same slicing
wdata_rdy  out  NUM_REQ  current write beat of owner consumed this cycle
rdata  out  DATA_W  read beat to owner
rdata_vld  out  NUM_REQ  read beat valid, owner bit only
rdata_last  out  1  qualifies final read beat
mem_avalid  out  1  address phase valid
mem_we  out  1  burst direction
mem_addr  out  ADDR_W  burst base address
mem_aready  in  1  address accepted
mem_wdata  out  DATA_W  write beat
mem_wvalid  out  1  write beat valid
mem_wready  in  1  write beat accepted
mem_rdata  in  DATA_W  read beat
mem_rvalid  in  1  read beat valid (no back-pressure)
busy  out  1  state != IDLE

Behaviour:

Reset:
- State goes to IDLE.
- rr_ptr, owner and beat_cnt clear to 0.
- All outputs are 0: req_gnt, wdata_rdy, rdata, rdata_vld, rdata_last, mem_avalid, mem_we, mem_addr, mem_wvalid, busy.
- Reset mid-burst abandons the transaction. There is no memory-side cleanup.

State machine IDLE -> ADDR -> (WDATA | RDATA) -> IDLE:
- IDLE: if any req_valid is set, select a winner by scanning from rr_ptr upward, modulo NUM_REQ.
  - Register owner, req_we[owner] and req_addr slice.
  - rr_ptr <= (owner+1) mod NUM_REQ.
  - Go to ADDR.
  - If no request is valid, stay in IDLE.
- ADDR:
  - req_gnt[owner]=1 in the first ADDR cycle only (registered, one cycle after selection).
  - mem_avalid=1; mem_addr and mem_we are held stable until mem_aready.
  - On mem_avalid&mem_aready: go to WDATA if we=1, else RDATA; beat_cnt=0.
- WDATA:
  - mem_wvalid=1 and mem_wdata = wdata[owner slice].
  - wdata_rdy[owner] = mem_wvalid & mem_wready, combinational.
  - Each accepted beat increments beat_cnt.
  - On acceptance of beat BURST_LEN-1, go to IDLE.
- RDATA:
  - Each mem_rvalid is registered: next cycle rdata=mem_rdata and rdata_vld[owner]=1 for exactly one cycle.
  - rdata_last=1 with beat BURST_LEN-1.
  - After capturing the last beat, go to IDLE. The last rdata_vld coincides with the first IDLE cycle.

Other rules:
- req_valid is ignored outside IDLE. A requester must drop req_valid the cycle after req_gnt unless it has another burst.
- Minimum gap between a burst's completion and the next grant pulse is 2 cycles (IDLE selection, then ADDR).
- beat_cnt is clog2(BURST_LEN) bits and wraps to 0 at burst end.
- mem_rvalid seen outside RDATA is ignored.
- busy=1 in ADDR, WDATA and RDATA.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index valid requester always wins, and rr_ptr is not implemented.
- Undefined: round-robin as above.

Test Plan:
1. After reset, req_valid=2'b01, req_we=0, req_addr0=0x100; mem_aready high; 4 mem_rvalid beats 0xA0..0xA3 -> req_gnt=01 one cycle; mem_addr=0x100, mem_we=0; rdata_vld[0] pulses 4 times with 0xA0..0xA3, each one cycle after the corresponding mem_rvalid; rdata_last only on 0xA3; busy drops after the last beat.
2. req_valid=2'b11 held continuously, all reads -> grant order 0,1,0,1; no burst overlap; rdata_vld[1] never high during requester 0's burst.
3. Requester 1 write to 0x2000, wdata stepping 0xD0..0xD3; mem_wready low on cycles 2-3 of WDATA -> wdata_rdy[1] only when mem_wready=1; exactly 4 beats 0xD0..0xD3 on mem_wdata; IDLE after the 4th.
4. mem_aready held low 3 cycles -> mem_avalid=1, mem_addr and mem_we unchanged for 4 cycles; req_gnt is a single pulse.
5. reset=0 during the 2nd read beat -> next cycle all outputs 0 and busy=0; a later req_valid=2'b10 is granted to 1, with the scan starting from rr_ptr=0.
6. With MEM_ARB_FIXED_PRIO_EN defined, req_valid=2'b11 held for 3 bursts -> requester 0 granted all 3 times.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst-oriented memory port between NUM_REQ cache requesters.
// Define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_gnt,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        wdata_rdy,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rdata_vld,
  output logic                      rdata_last,
  output logic                      mem_avalid,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_aready,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wvalid,
  input  logic                      mem_wready,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rvalid,
  output logic                      busy
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rvld_q, rvld_d;
  logic                rlast_q, rlast_d;

  logic                sel_found;
  logic [PTR_W-1:0]    sel_idx;
  logic [PTR_W-1:0]    scan_start;
  int unsigned         scan_cand;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  // Unpack the flat per-requester buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  assign scan_start = rr_ptr_q;
`endif

  // Winner: first valid requester scanning upward from scan_start, wrapping at NUM_REQ
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_cand = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_cand = 32'(scan_start) + k;
      if (scan_cand >= NUM_REQ) begin
        scan_cand = scan_cand - NUM_REQ;
      end
      if (!sel_found && req_valid[PTR_W'(scan_cand)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(scan_cand);
      end
    end
  end

  // Next-state and burst sequencing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = '0;
    rdata_d    = rdata_q;
    rvld_d     = '0;
    rlast_d    = 1'b0;
    wdata_rdy  = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_ADDR;
          owner_d = sel_idx;
          we_d    = req_we[sel_idx];
          addr_d  = addr_arr[sel_idx];
          gnt_d   = NUM_REQ'(1) << sel_idx;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_ptr_d = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
`endif
        end
      end
      ST_ADDR: begin
        if (mem_aready) begin
          state_d    = we_q ? ST_WDATA : ST_RDATA;
          beat_cnt_d = '0;
        end
      end
      ST_WDATA: begin
        if (mem_wready) begin
          wdata_rdy  = NUM_REQ'(1) << owner_q;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RDATA: begin
        if (mem_rvalid) begin
          rdata_d    = mem_rdata;
          rvld_d     = NUM_REQ'(1) << owner_q;
          rlast_d    = (beat_cnt_q == LAST_BEAT);
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      rvld_q     <= '0;
      rlast_q    <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      rdata_q    <= rdata_d;
      rvld_q     <= rvld_d;
      rlast_q    <= rlast_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign req_gnt    = gnt_q;
  assign rdata      = rdata_q;
  assign rdata_vld  = rvld_q;
  assign rdata_last = rlast_q;
  assign mem_avalid = (state_q == ST_ADDR);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wvalid = (state_q == ST_WDATA);
  assign mem_wdata  = (state_q == ST_WDATA) ? wdata_arr[owner_q] : '0;
  assign busy       = (state_q != ST_IDLE);

endmodule
